alu_exec_unit: RTL and testbench

Parametrised, handshaked ALU execution unit: decodes the 2-bit ALUOp and the 6-bit funct field into an internal operation, executes it on WIDTH-bit operands and returns a registered result. It extends the combinational ALU-control decode with operand datapath, valid/ready flow control and an optional iterative multi-cycle multiply. It sits between the main control/register-read stage and writeback.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_exec_unit_if.sv | 28 ++
 rtl/alu_decode.sv | 34 +++
 rtl/alu_exec_unit.sv | 141 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU execution unit: operation codes,
// ALUOp and funct encodings, and the control FSM state encoding.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_MUL = 4'b1000
    } op_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle of the ALU execution unit. The master side is the
// producer/consumer pair, the slave side is the unit itself.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [3:0]       op;
    logic             err;

    modport master (
        output in_valid, alu_op, funct, a, b, out_ready,
        input  in_ready, out_valid, result, zero, op, err
    );

    modport slave (
        input  in_valid, alu_op, funct, a, b, out_ready,
        output in_ready, out_valid, result, zero, op, err
    );
endinterface

// File: rtl/alu_decode.sv
// Combinational ALU-control decode: ALUOp + funct -> operation and illegal flag.
// MUL is decoded only when ALU_MULT_EN is defined; otherwise funct 011000 is illegal.
module alu_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output op_t        op,
    output logic       illegal
);
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        op      = OP_ADD;
        illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: op = OP_ADD;
            ALUOP_SUB: op = OP_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: op = OP_ADD;
                    FUNCT_SUB: op = OP_SUB;
                    FUNCT_AND: op = OP_AND;
                    FUNCT_OR:  op = OP_OR;
                    FUNCT_SLT: op = OP_SLT;
`ifdef ALU_MULT_EN
                    FUNCT_MUL: op = OP_MUL;
`endif
                    default:   illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution unit: IDLE/MUL/DONE control, single-cycle datapath and
// an iterative shift-add multiplier that exists only when ALU_MULT_EN is defined.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_unit_if.slave bus
);
    state_t           state_q, state_d;
    op_t              dec_op;
    logic             dec_illegal;
    logic [WIDTH-1:0] alu_y;
    logic             accept;
    logic             start_mul;
    logic             in_ready;
    logic             out_valid;

    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    op_t              op_q;
    logic             err_q;

    alu_decode u_decode (
        .alu_op  (bus.alu_op),
        .funct   (bus.funct),
        .op      (dec_op),
        .illegal (dec_illegal)
    );

    always_comb begin
        alu_y = '0;
        case (dec_op)
            OP_AND:  alu_y = bus.a & bus.b;
            OP_OR:   alu_y = bus.a | bus.b;
            OP_ADD:  alu_y = bus.a + bus.b;
            OP_SUB:  alu_y = bus.a - bus.b;
            OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default: alu_y = '0;
        endcase
        // An illegal request still reports ADD, but must return a zero result.
        if (dec_illegal) alu_y = '0;
    end

    assign accept = (state_q == ST_IDLE) && bus.in_valid;

`ifdef ALU_MULT_EN
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic             mul_last;

    assign start_mul = (dec_op == OP_MUL);
    assign mul_last  = (state_q == ST_MUL) && (cnt_q == CW'(WIDTH));

    // One shift-add step per cycle; the counter parks at WIDTH until the result is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (accept && start_mul) begin
            mcand_q  <= bus.a;
            mplier_q <= bus.b;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if ((state_q == ST_MUL) && (cnt_q != CW'(WIDTH))) begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
        end
    end
`else
    assign start_mul = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_d = start_mul ? ST_MUL : ST_DONE;
            end
`ifdef ALU_MULT_EN
            ST_MUL: begin
                if (mul_last) state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result registers change only when a new result is produced, so they hold through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            op_q     <= OP_AND;
            err_q    <= 1'b0;
        end else if (accept && !start_mul) begin
            result_q <= alu_y;
            zero_q   <= (alu_y == '0);
            op_q     <= dec_op;
            err_q    <= dec_illegal;
        end
`ifdef ALU_MULT_EN
        else if (mul_last) begin
            result_q <= acc_q;
            zero_q   <= (acc_q == '0);
            op_q     <= OP_MUL;
            err_q    <= 1'b0;
        end
`endif
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.op        = op_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_alu_exec_unit;
    localparam int W = 32;
`ifdef ALU_MULT_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   op;
        logic         err;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   rand_ready = 1'b0;
    int   checks = 0;
    int   failures = 0;

    bit   busy = 1'b0;
    int   cyc = 0;
    int   due = 0;
    exp_t cur;

    alu_exec_unit_if #(.WIDTH(W)) bus ();

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: what a request must produce and how long it takes.
    function automatic exp_t model(input logic [1:0] aop, input logic [5:0] f,
                                   input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic [2*W-1:0] prod;
        e.res = '0; e.op = 4'b0010; e.err = 1'b0; e.lat = 0;
        case (aop)
            2'b00: e.res = x + y;
            2'b01: begin e.op = 4'b0110; e.res = x - y; end
            2'b10: begin
                case (f)
                    6'h20: e.res = x + y;
                    6'h22: begin e.op = 4'b0110; e.res = x - y; end
                    6'h24: begin e.op = 4'b0000; e.res = x & y; end
                    6'h25: begin e.op = 4'b0001; e.res = x | y; end
                    6'h2a: begin e.op = 4'b0111; e.res = ($signed(x) < $signed(y)) ? 1 : 0; end
                    6'h18: begin
                        if (MUL_EN) begin
                            prod  = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                            e.op  = 4'b1000;
                            e.res = prod[W-1:0];
                            e.lat = W + 1;
                        end else e.err = 1'b1;
                    end
                    default: e.err = 1'b1;
                endcase
            end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // Bookkeeping of the outstanding request: acceptance, due edge and hand-off.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy = 1'b0;
        end else begin
            int cyc_old;
            cyc_old = cyc;
            cyc = cyc + 1;
            if (busy) begin
                if (cyc_old >= due && bus.out_ready) busy = 1'b0;
            end else if (bus.in_valid) begin
                busy = 1'b1;
                cur  = model(bus.alu_op, bus.funct, bus.a, bus.b);
                due  = cyc + cur.lat;
            end
        end
    end

    always @(negedge clk) begin
        logic exp_valid;
        exp_valid = rst_n && busy && (cyc >= due);
        check("in_ready", bus.in_ready, !(rst_n && busy));
        check("out_valid", bus.out_valid, exp_valid);
        if (exp_valid) begin
            check("result", bus.result, cur.res);
            check("zero", bus.zero, cur.res == '0);
            check("op", bus.op, cur.op);
            check("err", bus.err, cur.err);
        end
        if (!rst_n) begin
            check("rst_result", bus.result, 0);
            check("rst_op", bus.op, 0);
            check("rst_err", bus.err, 0);
            check("rst_zero", bus.zero, 0);
        end
    end

    always @(posedge clk) begin
        #2;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic issue(input logic [1:0] aop, input logic [5:0] f,
                         input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.alu_op   = aop;
        bus.funct    = f;
        bus.a        = x;
        bus.b        = y;
        while (!bus.in_ready && n < 1000) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 1000) begin
            checks++; failures++;
            $display("FAIL issue_timeout: in_ready never rose within %0d cycles", n);
        end
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
    endtask

    task automatic directed(input string name, input logic [1:0] aop, input logic [5:0] f,
                            input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [W-1:0] e_res, input logic [3:0] e_op,
                            input logic e_err, input int e_lat, input int hold);
        int n;
        bus.out_ready = (hold == 0);
        issue(aop, f, x, y);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        check({name, "_lat"}, n, e_lat);
        check({name, "_result"}, bus.result, e_res);
        check({name, "_zero"}, bus.zero, e_res == '0);
        check({name, "_op"}, bus.op, e_op);
        check({name, "_err"}, bus.err, e_err);
        repeat (hold) begin
            @(posedge clk); #2;
            check({name, "_hold_in_ready"}, bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #2;
        check({name, "_drain_out_valid"}, bus.out_valid, 0);
        check({name, "_drain_in_ready"}, bus.in_ready, 1);
    endtask

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'd1;
            5:       return W'($urandom_range(0, 15));
            default: return W'($urandom());
        endcase
    endfunction

    function automatic logic [5:0] pick_funct();
        case ($urandom_range(0, 7))
            0:       return 6'h20;
            1:       return 6'h22;
            2:       return 6'h24;
            3:       return 6'h25;
            4:       return 6'h2a;
            5:       return 6'h18;
            default: return 6'($urandom());
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: bench did not finish (checks=%0d failures=%0d)", checks, failures);
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        bus.in_valid = 1'b0; bus.alu_op = 2'b00; bus.funct = 6'h00;
        bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_result", bus.result, 0);
        check("reset_zero", bus.zero, 0);
        check("reset_op", bus.op, 0);
        check("reset_err", bus.err, 0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        directed("add", 2'b00, 6'h00, 5, 3, 8, 4'b0010, 0, 0, 0);
        directed("sub_alu01", 2'b01, 6'h3f, 10, 4, 6, 4'b0110, 0, 0, 0);
        directed("sub_wrap", 2'b10, 6'h22, 3, 5, 32'hFFFF_FFFE, 4'b0110, 0, 0, 0);
        directed("sub_zero", 2'b10, 6'h22, 7, 7, 0, 4'b0110, 0, 0, 0);
        directed("slt_neg", 2'b10, 6'h2a, 32'hFFFF_FFFF, 1, 1, 4'b0111, 0, 0, 0);
        directed("slt_pos", 2'b10, 6'h2a, 1, 32'hFFFF_FFFF, 0, 4'b0111, 0, 0, 0);
        directed("and", 2'b10, 6'h24, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 4'b0000, 0, 0, 0);
        directed("or", 2'b10, 6'h25, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 4'b0001, 0, 0, 2);
        directed("add_wrap", 2'b10, 6'h20, 32'hFFFF_FFFF, 2, 1, 4'b0010, 0, 0, 0);
        directed("bad_funct", 2'b10, 6'h3f, 9, 9, 0, 4'b0010, 1, 0, 0);
`ifdef ALU_MULT_EN
        directed("mul", 2'b10, 6'h18, 7, 6, 42, 4'b1000, 0, W + 1, 0);
        directed("mul_neg", 2'b10, 6'h18, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFD, 4'b1000, 0, W + 1, 3);
`else
        directed("mul_off", 2'b10, 6'h18, 7, 6, 0, 4'b0010, 1, 0, 0);
`endif

        // Reserved ALUOp under backpressure, with a competing request held meanwhile.
        bus.out_ready = 1'b0;
        issue(2'b11, 6'h20, 32'h1234, 32'h5678);
        check("ill_out_valid", bus.out_valid, 1);
        check("ill_result", bus.result, 0);
        check("ill_err", bus.err, 1);
        check("ill_op", bus.op, 4'b0010);
        check("ill_zero", bus.zero, 1);
        bus.in_valid = 1'b1; bus.alu_op = 2'b00; bus.a = 1; bus.b = 1;
        repeat (5) begin
            @(posedge clk); #2;
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_err", bus.err, 1);
            check("bp_result", bus.result, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #2;
        check("bp_after_out_valid", bus.out_valid, 0);
        check("bp_after_in_ready", bus.in_ready, 1);
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
        check("bp_next_valid", bus.out_valid, 1);
        check("bp_next_result", bus.result, 2);
        @(posedge clk); #2;

        // Reset part-way through a multiply (or while a result waits in DONE).
        bus.out_ready = 1'b0;
        issue(2'b10, 6'h18, 7, 6);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_result", bus.result, 0);
        check("midrst_op", bus.op, 0);
        check("midrst_err", bus.err, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        directed("post_rst_add", 2'b00, 6'h00, 100, 23, 123, 4'b0010, 0, 0, 0);

        rand_ready = 1'b1;
        repeat (300) begin
            logic [1:0] aop;
            aop = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) aop = 2'b10;
            issue(aop, pick_funct(), pick_val(), pick_val());
        end
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while ((bus.out_valid || !bus.in_ready) && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        check("drain_idle", bus.in_ready, 1);
        @(posedge clk); #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
